// File: rtl/sd_cic_decimator.sv
// Third-order CIC decimator for a two-wire sigma-delta pulse stream.
// Three integrators run at the input sample rate and three unit-delay combs
// run once per frame of DECIM accepted samples. All internal arithmetic is
// modulo 2^IW; the CIC structure makes the final result exact despite
// intermediate wrap-around. dout is the sign-extended comb result.
module sd_cic_decimator #(
    parameter int BITWIDTH   = 32,
    parameter int LOG2_DECIM = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          sd_in,
    input  logic                en,
    output logic [BITWIDTH-1:0] dout,
    output logic                dout_valid
);

    // Internal width is exactly enough for gain DECIM^3 plus sign and headroom.
    localparam int IW = 3 * LOG2_DECIM + 2;

    localparam logic [IW-1:0]         X_ZERO    = {IW{1'b0}};
    localparam logic [IW-1:0]         X_PLUS    = IW'(1);
    localparam logic [IW-1:0]         X_MINUS   = {IW{1'b1}};
    localparam logic [LOG2_DECIM-1:0] CNT_ZERO  = {LOG2_DECIM{1'b0}};
    localparam logic [LOG2_DECIM-1:0] CNT_ONE   = LOG2_DECIM'(1);
    localparam logic [LOG2_DECIM-1:0] CNT_LAST  = {LOG2_DECIM{1'b1}};
    localparam logic [BITWIDTH-1:0]   DOUT_ZERO = {BITWIDTH{1'b0}};

    // Maps the pulse pair onto a signed unit step; coincident pulses cancel.
    function automatic logic [IW-1:0] decode_sd(input logic [1:0] sd);
        logic [IW-1:0] x;
        case (sd)
            2'b01:   x = X_PLUS;
            2'b10:   x = X_MINUS;
            2'b00:   x = X_ZERO;
            2'b11:   x = X_ZERO;
            default: x = X_ZERO;
        endcase
        return x;
    endfunction

    // Sign-extends a comb result to the output width.
    function automatic logic [BITWIDTH-1:0] sext_out(input logic [IW-1:0] v);
        return BITWIDTH'($signed(v));
    endfunction

    logic [IW-1:0]         x_s;
    logic [IW-1:0]         i1_r, i2_r, i3_r;
    logic [IW-1:0]         i1_nxt_s, i2_nxt_s, i3_nxt_s;
    logic [IW-1:0]         d1_r, d2_r, d3_r;
    logic [IW-1:0]         c1_s, c2_s, c3_s;
    logic [LOG2_DECIM-1:0] cnt_r;
    logic [LOG2_DECIM-1:0] cnt_nxt_s;
    logic                  tick_s;
    logic                  pending_r;
    logic [BITWIDTH-1:0]   dout_r;
    logic                  dout_valid_r;

    // Input decode and integrator chain; each stage sees the freshly updated upstream value.
    always_comb begin
        x_s      = decode_sd(sd_in);
        i1_nxt_s = i1_r + x_s;
        i2_nxt_s = i2_r + i1_nxt_s;
        i3_nxt_s = i3_r + i2_nxt_s;
    end

    // Frame counter advance and end-of-frame detection on accepted samples only.
    always_comb begin
        cnt_nxt_s = cnt_r + CNT_ONE;
        if (en && (cnt_r == CNT_LAST)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
    end

    // Comb cascade evaluated from the integrator output held after the tick.
    always_comb begin
        c1_s = i3_r - d1_r;
        c2_s = c1_s - d2_r;
        c3_s = c2_s - d3_r;
    end

    // Integrator state; frozen whenever no sample is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i1_r <= X_ZERO;
            i2_r <= X_ZERO;
            i3_r <= X_ZERO;
        end else if (en) begin
            i1_r <= i1_nxt_s;
            i2_r <= i2_nxt_s;
            i3_r <= i3_nxt_s;
        end else begin
            i1_r <= i1_r;
            i2_r <= i2_r;
            i3_r <= i3_r;
        end
    end

    // Sample counter wraps naturally from DECIM-1 back to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= CNT_ZERO;
        end else if (en) begin
            cnt_r <= cnt_nxt_s;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Remembers that a frame just closed so the combs run on the next edge regardless of en.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_r <= 1'b0;
        end else begin
            pending_r <= tick_s;
        end
    end

    // Comb delay registers load once per frame alongside the output sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d1_r <= X_ZERO;
            d2_r <= X_ZERO;
            d3_r <= X_ZERO;
        end else if (pending_r) begin
            d1_r <= i3_r;
            d2_r <= c1_s;
            d3_r <= c2_s;
        end else begin
            d1_r <= d1_r;
            d2_r <= d2_r;
            d3_r <= d3_r;
        end
    end

    // Output sample register and its single-cycle strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_r       <= DOUT_ZERO;
            dout_valid_r <= 1'b0;
        end else if (pending_r) begin
            dout_r       <= sext_out(c3_s);
            dout_valid_r <= 1'b1;
        end else begin
            dout_r       <= dout_r;
            dout_valid_r <= 1'b0;
        end
    end

    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;

endmodule

// File: tb/tb_sd_cic_decimator.sv
// Directed bench for sd_cic_decimator at default parameters (DECIM = 64).
// Expected periods are counted in clock edges from reset release or from the
// cycle after the previous strobe; expected samples are hand-derived from
// i3(n) = n(n+1)(n+2)/6 for a constant +1 input.
module tb_sd_cic_decimator;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  sd_in;
    logic        en;
    logic [31:0] dout;
    logic        dout_valid;

    int   vectors     = 0;
    int   miscompares = 0;
    logic alt_mode    = 1'b0;
    logic en_toggle   = 1'b0;

    always #5 clk = ~clk;

    sd_cic_decimator #(
        .BITWIDTH   (32),
        .LOG2_DECIM (6)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sd_in      (sd_in),
        .en         (en),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // One clock edge; outputs are stable 1 time unit later. Pattern modes advance here.
    task automatic tick1();
        @(posedge clk);
        #1;
        if (alt_mode) sd_in = ~sd_in;
        if (en_toggle) en = ~en;
    endtask

    task automatic wait_valid(input int budget, output int cycles);
        cycles = 0;
        while (cycles < budget) begin
            tick1();
            cycles++;
            if (dout_valid) break;
        end
    endtask

    // Waits for the next strobe, checks its spacing and value, then checks the strobe drops.
    task automatic expect_frame(input string tag, input int exp_cycles,
                                input logic chk_val, input logic [31:0] exp_dout);
        int c;
        wait_valid(exp_cycles + 8, c);
        check({tag, "_period"}, c, exp_cycles);
        if (chk_val) check({tag, "_dout"}, dout, exp_dout);
        tick1();
        check({tag, "_strobe_len"}, {31'd0, dout_valid}, 32'd0);
        if (chk_val) check({tag, "_hold"}, dout, exp_dout);
    endtask

    task automatic do_reset(input logic [1:0] sd, input logic e, input logic alt, input logic etog);
        @(negedge clk);
        reset     = 1'b0;
        alt_mode  = 1'b0;
        en_toggle = 1'b0;
        #1;
        check("rst_dout", dout, 32'd0);
        check("rst_valid", {31'd0, dout_valid}, 32'd0);
        repeat (2) @(negedge clk);
        sd_in     = sd;
        en        = e;
        alt_mode  = alt;
        en_toggle = etog;
        reset     = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        reset = 1'b0;
        sd_in = 2'b00;
        en    = 1'b0;
        repeat (3) @(negedge clk);
        check("init_dout", dout, 32'd0);
        check("init_valid", {31'd0, dout_valid}, 32'd0);

        // Constant +1: ramp-up then steady DECIM^3; later frames run with i3 wrapped.
        do_reset(2'b01, 1'b1, 1'b0, 1'b0);
        expect_frame("pos_f1", 65, 1'b1, 32'd45760);
        expect_frame("pos_f2", 63, 1'b1, 32'd220480);
        expect_frame("pos_f3", 63, 1'b1, 32'd262144);
        expect_frame("pos_f4", 63, 1'b1, 32'd262144);
        expect_frame("pos_f5", 63, 1'b1, 32'd262144);
        expect_frame("pos_wrap", 63, 1'b1, 32'd262144);

        // Constant -1.
        do_reset(2'b10, 1'b1, 1'b0, 1'b0);
        expect_frame("neg_f1", 65, 1'b1, -32'sd45760);
        expect_frame("neg_f2", 63, 1'b1, -32'sd220480);
        expect_frame("neg_f3", 63, 1'b1, -32'sd262144);
        expect_frame("neg_f4", 63, 1'b1, -32'sd262144);

        // Coincident pulses cancel from the very first output.
        do_reset(2'b11, 1'b1, 1'b0, 1'b0);
        expect_frame("both_f1", 65, 1'b1, 32'd0);
        expect_frame("both_f2", 63, 1'b1, 32'd0);

        // Alternating +1/-1 is nulled once the filter memory is filled.
        do_reset(2'b01, 1'b1, 1'b1, 1'b0);
        expect_frame("alt_f1", 65, 1'b0, 32'd0);
        expect_frame("alt_f2", 63, 1'b0, 32'd0);
        expect_frame("alt_f3", 63, 1'b1, 32'd0);
        expect_frame("alt_f4", 63, 1'b1, 32'd0);

        // en toggling halves the sample rate; values are unchanged.
        do_reset(2'b01, 1'b1, 1'b0, 1'b1);
        expect_frame("tog_f1", 128, 1'b1, 32'd45760);
        expect_frame("tog_f2", 127, 1'b1, 32'd220480);
        expect_frame("tog_f3", 127, 1'b1, 32'd262144);

        // Comb update still happens when en drops right after the tick; state then freezes.
        do_reset(2'b01, 1'b1, 1'b0, 1'b0);
        repeat (64) tick1();
        en = 1'b0;
        tick1();
        check("hold_valid", {31'd0, dout_valid}, 32'd1);
        check("hold_dout", dout, 32'd45760);
        nv = 0;
        repeat (20) begin
            tick1();
            if (dout_valid) nv++;
        end
        check("hold_no_strobe", nv, 32'd0);
        check("hold_dout_kept", dout, 32'd45760);
        en = 1'b1;
        expect_frame("hold_f2", 65, 1'b1, 32'd220480);

        // Reset in the second frame at sample 40 clears outputs at once and restarts framing.
        do_reset(2'b01, 1'b1, 1'b0, 1'b0);
        expect_frame("mid_f1", 65, 1'b1, 32'd45760);
        repeat (37) tick1();
        reset = 1'b0;
        #1;
        check("mid_rst_dout", dout, 32'd0);
        check("mid_rst_valid", {31'd0, dout_valid}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        expect_frame("mid_after", 65, 1'b1, 32'd45760);

        // Reset in the cycle after a tick discards the pending comb update.
        do_reset(2'b01, 1'b1, 1'b0, 1'b0);
        repeat (64) tick1();
        reset = 1'b0;
        #1;
        check("pend_rst_valid", {31'd0, dout_valid}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        expect_frame("pend_after", 65, 1'b1, 32'd45760);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sd_cic_decimator.md
SD_CIC_DECIMATOR -- requirements
Module: sd_cic_decimator

Interface
REQ-001 SHALL have parameter BITWIDTH, default 32, output sample width; BITWIDTH >= 3*LOG2_DECIM+2.
REQ-002 SHALL have parameter LOG2_DECIM, default 6, log2 of the decimation ratio; DECIM = 2^LOG2_DECIM.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 SHALL have port sd_in  input  2  two-piece sigma-delta pulse pair from the modulator stage.
REQ-006 SHALL have port en  input  1  sample enable; sd_in accepted only on edges where en=1.
REQ-007 SHALL have port dout  output  BITWIDTH  signed decimated sample, two's complement.
REQ-008 SHALL have port dout_valid  output  1  one-cycle strobe marking a new dout.

Function
REQ-009 SHALL decode sd_in to signed input x: 2'b01 -> +1, 2'b10 -> -1, 2'b00 -> 0, 2'b11 -> 0 (simultaneous pulses cancel).
REQ-010 SHALL implement a 3rd-order CIC decimator: three cascaded integrators at input rate, three comb stages (differential delay 1) at output rate.
REQ-011 SHALL use internal width IW = 3*LOG2_DECIM+2 (20 at default) for all integrators, comb delay registers and comb results.
REQ-012 SHALL use modulo-2^IW wrap-around arithmetic in integrators and combs; no saturation, no overflow flag.
REQ-013 SHALL update integrators only on edges with en=1: i1 += x, i2 += new i1, i3 += new i2 (all three updated on the same edge, each using the upstream stage's post-update value).
REQ-014 SHALL hold a sample counter 0..DECIM-1, incremented on each accepted sample, wrapping DECIM-1 -> 0.
REQ-015 SHALL define a decimation tick as the edge accepting a sample while counter = DECIM-1 (the DECIM-th sample of a frame).
REQ-016 SHALL, on the edge after a tick (regardless of en), compute c1 = i3 - d1, c2 = c1 - d2, c3 = c2 - d3 from the post-tick i3, register dout = sign-extend(c3) to BITWIDTH, and load d1 <- i3, d2 <- c1, d3 <- c2.
REQ-017 SHALL assert dout_valid for exactly one cycle following that edge; dout SHALL hold its value until the next such edge.
REQ-018 SHALL give latency of one clock from tick edge to dout/dout_valid update.
REQ-019 SHALL leave counter and integrators frozen while en=0; a pending comb update (REQ-016) SHALL still occur on the following edge.
REQ-020 SHALL produce steady-state gain DECIM^3: constant +1 -> +2^(3*LOG2_DECIM), constant -1 -> -2^(3*LOG2_DECIM).
REQ-021 SHALL NOT emit dout_valid on two consecutive cycles (guaranteed since DECIM >= 2).

Reset
REQ-022 SHALL, while reset=0, asynchronously clear counter, i1..i3, d1..d3, dout to 0 and dout_valid to 0.
REQ-023 SHALL, on reset assertion mid-frame or in the cycle after a tick, discard the partial frame and the pending comb update; no dout_valid until DECIM accepted samples after release.
REQ-024 SHALL accept the first sample on the first rising edge with reset=1 and en=1.

Verification
REQ-025 SHALL pass: defaults, en=1, sd_in=2'b01 constant from reset release -> dout_valid pulses every 64 cycles, dout = 45760, 220480, 262144, then 262144 thereafter.
REQ-026 SHALL pass: defaults, sd_in=2'b10 constant -> dout = -45760, -220480, -262144, then -262144 steady.
REQ-027 SHALL pass: sd_in alternating 2'b01/2'b10 each cycle, or held 2'b11 -> all dout = 0 after settling; 2'b11 gives 0 from the first output.
REQ-028 SHALL pass: sd_in=2'b01, en toggling 1,0,1,0... -> dout_valid every 128 cycles, same value sequence as REQ-025.
REQ-029 SHALL pass: reset pulsed low at sample 40 of the second frame -> outputs cleared immediately; next dout_valid 64 accepted samples after release with dout = 45760.
REQ-030 SHALL pass: constant +1 run long enough for i3 to wrap past 2^IW -> dout remains 262144 (wrap-around transparency).
